// File: rtl/chunk_packer_if.sv
// Handshake bundle between a narrow chunk producer, the chunk packer and a wide-word consumer.
// The slave modport is the packer's view; the master modport is the surrounding logic's view.
interface chunk_packer_if #(
   parameter int WIDTH_I = 4,
   parameter int WIDTH_O = 16
);
   localparam int NW = $clog2(WIDTH_O / WIDTH_I) + 1;

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH_I-1:0] in_data;
   logic               in_sof;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH_O-1:0] out_data;
   logic [NW-1:0]      out_nchunks;
   logic               out_partial;
   logic               sof_err;

   modport slave (
      input  in_valid, in_data, in_sof, flush, out_ready,
      output in_ready, out_valid, out_data, out_nchunks, out_partial, sof_err
   );

   modport master (
      output in_valid, in_data, in_sof, flush, out_ready,
      input  in_ready, out_valid, out_data, out_nchunks, out_partial, sof_err
   );
endinterface

// File: rtl/chunk_packer.sv
// Packs WIDTH_I-bit chunks MSB-first into WIDTH_O-bit words; a full word appears one cycle after its last chunk.
// Stalls input only on the last chunk of a word (or a pending flush) while the one-deep output register is occupied.
module chunk_packer #(
   parameter int WIDTH_I = 4,
   parameter int WIDTH_O = 16
) (
   input logic            clk,
   input logic            rst_n,
   chunk_packer_if.slave  bus
);
   localparam int RATIO = WIDTH_O / WIDTH_I;
   localparam int CW    = $clog2(RATIO);
   localparam int NW    = CW + 1;
   localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

   generate
      if ((WIDTH_O % WIDTH_I) != 0 || RATIO < 2) begin : g_bad_params
         $error("chunk_packer: WIDTH_O must be a multiple of WIDTH_I with ratio >= 2");
      end
   endgenerate

   logic [WIDTH_O-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH_O-1:0] odata_q, odata_d;
   logic [NW-1:0]      onch_q, onch_d;
   logic               opart_q, opart_d;
   logic               ovld_q, ovld_d;
   logic               pend_q, pend_d;
   logic               serr_q, serr_d;

   logic               out_free;
   logic               in_rdy;
   logic               accept;
   logic               flush_req;
   logic               load;
   logic [WIDTH_O-1:0] word;
   logic [NW-1:0]      word_n;
   logic               word_part;

   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      odata_d   = odata_q;
      onch_d    = onch_q;
      opart_d   = opart_q;
      ovld_d    = ovld_q;
      pend_d    = pend_q;
      serr_d    = serr_q;
      load      = 1'b0;
      word      = '0;
      word_n    = '0;
      word_part = 1'b0;

      out_free  = !ovld_q || bus.out_ready;
      in_rdy    = !pend_q && !((cnt_q == LAST) && !out_free);
      accept    = bus.in_valid && in_rdy;
      flush_req = bus.flush || pend_q;

      // Unfilled accumulator slots are kept at zero so a flushed partial is zero-padded.
      if (accept) begin
         if (bus.in_sof && (cnt_q != '0)) begin
            acc_d = '0;
            acc_d[WIDTH_O-1 -: WIDTH_I] = bus.in_data;
            cnt_d  = CW'(1);
            serr_d = 1'b1;
         end else if (cnt_q == LAST) begin
            word = acc_q;
            word[WIDTH_I-1:0] = bus.in_data;
            word_n = NW'(RATIO);
            load   = 1'b1;
            acc_d  = '0;
            cnt_d  = '0;
         end else begin
            for (int k = 0; k < RATIO; k++) begin
               if (int'(cnt_q) == k) begin
                  acc_d[WIDTH_O-1-k*WIDTH_I -: WIDTH_I] = bus.in_data;
               end
            end
            cnt_d = cnt_q + 1'b1;
         end
      end

      // Flush sees the count after this edge's chunk, so a just-completed word makes it a no-op.
      if (flush_req && (cnt_d != '0)) begin
         if (out_free) begin
            word      = acc_d;
            word_n    = {1'b0, cnt_d};
            word_part = 1'b1;
            load      = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
            pend_d    = 1'b0;
         end else begin
            pend_d = 1'b1;
         end
      end

      if (load) begin
         ovld_d  = 1'b1;
         odata_d = word;
         onch_d  = word_n;
         opart_d = word_part;
      end else if (bus.out_ready) begin
         ovld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         odata_q <= '0;
         onch_q  <= '0;
         opart_q <= 1'b0;
         ovld_q  <= 1'b0;
         pend_q  <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         odata_q <= odata_d;
         onch_q  <= onch_d;
         opart_q <= opart_d;
         ovld_q  <= ovld_d;
         pend_q  <= pend_d;
         serr_q  <= serr_d;
      end
   end

   assign bus.in_ready    = in_rdy;
   assign bus.out_valid   = ovld_q;
   assign bus.out_data    = odata_q;
   assign bus.out_nchunks = onch_q;
   assign bus.out_partial = opart_q;
   assign bus.sof_err     = serr_q;

   a_hold_stalled: assert property (@(posedge clk) disable iff (!rst_n)
      (ovld_q && !bus.out_ready) |=> (ovld_q && $stable(odata_q) && $stable(onch_q) && $stable(opart_q)));

endmodule

// File: tb/tb_chunk_packer.sv
// Directed bench for chunk_packer: stimulus pushes expected words into a queue, a negedge monitor pops and compares.
module tb_chunk_packer;
   localparam int WI = 4;
   localparam int WO = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   chunk_packer_if #(.WIDTH_I(WI), .WIDTH_O(WO)) ifc();
   chunk_packer #(.WIDTH_I(WI), .WIDTH_O(WO)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

   typedef struct packed {
      logic [15:0] d;
      logic [2:0]  n;
      logic        p;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && ifc.out_valid && ifc.out_ready) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %h want none", ifc.out_data);
         end else begin
            e = q.pop_front();
            check("out_data", 32'(ifc.out_data), 32'(e.d));
            check("out_nchunks", 32'(ifc.out_nchunks), 32'(e.n));
            check("out_partial", 32'(ifc.out_partial), 32'(e.p));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves in_valid high so consecutive calls stream back-to-back.
   task automatic send(input logic [3:0] d, input logic sof);
      int n;
      logic r;
      ifc.in_valid = 1'b1;
      ifc.in_data  = d;
      ifc.in_sof   = sof;
      n = 0;
      do begin
         @(negedge clk);
         r = ifc.in_ready;
         tick();
         n++;
      end while (!r && n < 40);
      if (!r) begin
         total++;
         bad++;
         $display("FAIL send_timeout: chunk %h never accepted, want accepted", d);
      end
      ifc.in_sof = 1'b0;
   endtask

   task automatic idle();
      ifc.in_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      ifc.flush = 1'b1;
      tick();
      ifc.flush = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      check(name, 32'(q.size()), 0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      ifc.in_valid  = 1'b0;
      ifc.in_data   = '0;
      ifc.in_sof    = 1'b0;
      ifc.flush     = 1'b0;
      ifc.out_ready = 1'b0;

      // Reset state
      #12;
      check("rst_out_valid", 32'(ifc.out_valid), 0);
      check("rst_out_data", 32'(ifc.out_data), 0);
      check("rst_sof_err", 32'(ifc.sof_err), 0);
      #10 rst_n = 1'b1;
      tick();
      check("rst_in_ready", 32'(ifc.in_ready), 1);

      // Full word, single-cycle valid pulse
      ifc.out_ready = 1'b1;
      q.push_back('{16'hABCD, 3'd4, 1'b0});
      send(4'hA, 1'b0); send(4'hB, 1'b0); send(4'hC, 1'b0); send(4'hD, 1'b0);
      idle();
      @(negedge clk);
      check("abcd_valid_rise", 32'(ifc.out_valid), 1);
      tick();
      @(negedge clk);
      check("abcd_valid_fall", 32'(ifc.out_valid), 0);
      tick();
      drain("abcd_drain");

      // Backpressure: stall on last chunk, then back-to-back words
      ifc.out_ready = 1'b0;
      send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
      send(4'h5, 1'b0); send(4'h6, 1'b0); send(4'h7, 1'b0);
      ifc.in_data = 4'h8;
      @(negedge clk);
      check("bp_in_ready_low", 32'(ifc.in_ready), 0);
      check("bp_hold_data", 32'(ifc.out_data), 32'h1234);
      @(negedge clk);
      check("bp_hold_data2", 32'(ifc.out_data), 32'h1234);
      check("bp_hold_valid", 32'(ifc.out_valid), 1);
      tick();
      q.push_back('{16'h1234, 3'd4, 1'b0});
      q.push_back('{16'h5678, 3'd4, 1'b0});
      ifc.out_ready = 1'b1;
      send(4'h8, 1'b0);
      idle();
      @(negedge clk);
      check("bp_no_bubble_valid", 32'(ifc.out_valid), 1);
      check("bp_no_bubble_data", 32'(ifc.out_data), 32'h5678);
      tick();
      drain("bp_drain");

      // Flush of a partial word, then flush on empty is a no-op
      q.push_back('{16'h1200, 3'd2, 1'b1});
      send(4'h1, 1'b0); send(4'h2, 1'b0);
      idle();
      pulse_flush();
      drain("flush_drain");
      pulse_flush();
      tick();
      @(negedge clk);
      check("flush_empty_noop", 32'(ifc.out_valid), 0);
      tick();
      q.push_back('{16'h3456, 3'd4, 1'b0});
      send(4'h3, 1'b1); send(4'h4, 1'b0); send(4'h5, 1'b0); send(4'h6, 1'b0);
      idle();
      drain("after_flush_drain");
      check("sof_at_zero_no_err", 32'(ifc.sof_err), 0);

      // in_sof mid-word discards the partial
      q.push_back('{16'h789A, 3'd4, 1'b0});
      send(4'h5, 1'b0); send(4'h6, 1'b0); send(4'h7, 1'b1);
      send(4'h8, 1'b0); send(4'h9, 1'b0); send(4'hA, 1'b0);
      idle();
      drain("sof_drain");
      check("sof_err_set", 32'(ifc.sof_err), 1);

      // Flush while output register is occupied becomes pending
      ifc.out_ready = 1'b0;
      q.push_back('{16'h1234, 3'd4, 1'b0});
      q.push_back('{16'hC000, 3'd1, 1'b1});
      send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
      send(4'hC, 1'b0);
      idle();
      pulse_flush();
      @(negedge clk);
      check("pend_in_ready_low", 32'(ifc.in_ready), 0);
      check("pend_hold_data", 32'(ifc.out_data), 32'h1234);
      tick();
      ifc.out_ready = 1'b1;
      drain("pend_drain");
      check("sof_err_sticky", 32'(ifc.sof_err), 1);

      // Asynchronous reset mid-word
      send(4'h1, 1'b0); send(4'h2, 1'b0);
      idle();
      #3 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(ifc.out_valid), 0);
      check("arst_out_data", 32'(ifc.out_data), 0);
      check("arst_out_nchunks", 32'(ifc.out_nchunks), 0);
      check("arst_out_partial", 32'(ifc.out_partial), 0);
      check("arst_sof_err", 32'(ifc.sof_err), 0);
      #10 rst_n = 1'b1;
      tick();
      q.push_back('{16'hBEEF, 3'd4, 1'b0});
      send(4'hB, 1'b0); send(4'hE, 1'b0); send(4'hE, 1'b0); send(4'hF, 1'b0);
      idle();
      drain("arst_drain");
      check("arst_sof_err_after", 32'(ifc.sof_err), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/chunk_packer.md
CHUNK_PACKER -- requirements
Module: chunk_packer

Interface
REQ-001 The block SHALL have parameter WIDTH_I, default 4, meaning the input chunk width in bits.
REQ-002 The block SHALL have parameter WIDTH_O, default 16, meaning the packed output word width.
- WIDTH_O SHALL be an integer multiple of WIDTH_I.
- RATIO = WIDTH_O/WIDTH_I SHALL be >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data carries a chunk.
REQ-006 in_ready  output  1  block accepts a chunk this cycle.
REQ-007 in_data  input  WIDTH_I  received chunk, MSB-first order within word.
REQ-008 in_sof  input  1  accepted chunk is the first chunk of a new word; qualified by in_valid&in_ready.
REQ-009 flush  input  1  single-cycle request to emit the current partial word.
REQ-010 out_valid  output  1  out_data holds a packed word.
REQ-011 out_ready  input  1  consumer takes the word this cycle.
REQ-012 out_data  output  WIDTH_O  packed word.
REQ-013 out_nchunks  output  $clog2(RATIO)+1  count of valid chunks in out_data (1..RATIO).
REQ-014 out_partial  output  1  out_data was produced by flush with fewer than RATIO chunks.
REQ-015 sof_err  output  1  sticky; a partial word was discarded by in_sof.

Function
REQ-016 Storage SHALL be:
- an accumulator (WIDTH_O bits);
- a chunk counter cnt (0..RATIO-1);
- a one-deep output register (data, nchunks, partial, valid);
- a flush_pend flag.
REQ-017 A chunk SHALL be accepted on a rising edge where in_valid&in_ready=1.
- The k-th accepted chunk (k=0 first) SHALL occupy accumulator bits [WIDTH_O-1-k*WIDTH_I -: WIDTH_I].
REQ-018 The output register SHALL be "free" when out_valid=0 or out_ready=1.
REQ-019 in_ready SHALL be 0 when flush_pend=1.
- Otherwise in_ready SHALL be 0 only when cnt=RATIO-1 and the output register is not free.
- in_ready SHALL be 1 in all other cases.
- in_ready MAY depend combinationally on out_ready.
REQ-020 On acceptance with cnt=RATIO-1, the completed word SHALL be loaded into the output register on the same edge.
- out_valid SHALL rise the following cycle, giving one-cycle latency from the last chunk.
- On that load: out_nchunks=RATIO, out_partial=0, cnt=0, accumulator cleared to 0.
REQ-021 On acceptance with cnt<RATIO-1 and in_sof=0, cnt SHALL increment by 1.
REQ-022 On acceptance with in_sof=1 and cnt!=0:
- the old partial SHALL be discarded;
- the chunk SHALL be placed as chunk 0, with cnt=1 afterwards;
- sof_err SHALL set to 1.
REQ-023 in_sof=1 with cnt=0 SHALL behave as a normal first chunk and SHALL NOT set sof_err.
REQ-024 flush=1 SHALL act on the accumulator after any chunk accepted on the same edge.
- If the resulting count is 0 (empty, or the word just completed), flush SHALL be a no-op.
REQ-025 If flush acts on a nonzero count n and the output register is free, the partial word SHALL load on that edge.
- Unused low-order bits SHALL be zero.
- On that load: out_nchunks=n, out_partial=1, cnt=0.
REQ-026 If flush acts on a nonzero count and the output register is not free, flush_pend SHALL set.
- The partial word SHALL load on the first edge the register is free.
- flush_pend SHALL clear on that same edge.
REQ-027 out_valid SHALL clear on out_valid&out_ready unless a new word loads on the same edge.
- A new word loading on that edge SHALL keep out_valid=1 with the new contents, with no bubble.
REQ-028 out_data, out_nchunks and out_partial SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 sof_err SHALL clear only on reset.

Reset
REQ-030 rst_n=0 SHALL immediately force the following, regardless of clk:
- cnt=0, accumulator=0, flush_pend=0;
- out_valid=0, out_data=0, out_nchunks=0, out_partial=0;
- sof_err=0.
REQ-031 in_ready SHALL be 1 while rst_n=1 and state is at reset values.
REQ-032 Reset asserted mid-word SHALL discard the partial word with no output.
- The first chunk after release SHALL be chunk 0.

Verification
REQ-033 Stream A,B,C,D with out_ready=1:
- out_data=16'hABCD, out_nchunks=4, out_partial=0;
- out_valid high exactly one cycle, starting the cycle after D is accepted.
REQ-034 out_ready=0, stream 1,2,3,4,5,6,7,8:
- out_data=16'h1234 held;
- in_ready=0 while 8 is presented;
- raise out_ready -> 16'h1234 then 16'h5678, back-to-back.
REQ-035 Accept 1,2, then pulse flush:
- out_data=16'h1200, out_nchunks=2, out_partial=1;
- next chunks 3,4,5,6 -> 16'h3456.
REQ-036 Accept 5,6, then 7 with in_sof=1, then 8,9,A:
- out_data=16'h789A;
- sof_err=1 and remains 1.
REQ-037 Output holding 16'h1234 with out_ready=0, accept C, pulse flush:
- in_ready=0;
- after out_ready=1: 16'h1234 then 16'hC000 with out_partial=1, out_nchunks=1.
REQ-038 Accept 1,2, pulse rst_n low mid-cycle:
- outputs zero immediately;
- after release, chunks B,E,E,F -> 16'hBEEF, sof_err=0.
